// File: rtl/op_buf_drain_packer.sv
// Drains a run of output-buffer words, packs word pairs into host beats through a
// small FIFO and delivers them under valid/ready, pulsing done after the final beat.
module op_buf_drain_packer #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter int OUT_W      = 2 * DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_base,
    input  logic [ADDR_W:0]   start_count,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   RUN_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     issued_q, issued_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_odd_q, rd_odd_d;
    logic                rd_last_q, rd_last_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_odd_q, rsp_odd_d;
    logic                rsp_last_q, rsp_last_d;
    logic [DATA_W-1:0]   pack_q, pack_d;
    logic [CNT_W-1:0]    reserved_q, reserved_d;
    logic [CNT_W-1:0]    fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OUT_W:0]      fifo_q [FIFO_DEPTH];
    logic [OUT_W:0]      fifo_d [FIFO_DEPTH];

    logic                issue_even;
    logic                push;
    logic                pop;
    logic                fifo_nonempty;
    logic [OUT_W:0]      push_entry;
    logic [OUT_W:0]      head_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_ONE;
    endfunction

    // Each FIFO entry is {last, beat}; only the entry under the write pointer changes.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_wr
        assign fifo_d[gi] = (push && (wr_ptr_q == PTR_W'(gi))) ? push_entry : fifo_q[gi];
    end

    always_comb begin
        fifo_nonempty = (fifo_count_q != '0);
        head_entry    = fifo_q[rd_ptr_q];
        pop           = fifo_nonempty && out_ready;

        push       = rsp_valid_q && (rsp_odd_q || rsp_last_q);
        push_entry = rsp_odd_q ? {rsp_last_q, rd_data, pack_q}
                               : {rsp_last_q, {DATA_W{1'b0}}, rd_data};
        pack_d     = (rsp_valid_q && !rsp_odd_q) ? rd_data : pack_q;

        rsp_valid_d = rd_en_q;
        rsp_odd_d   = rd_odd_q;
        rsp_last_d  = rd_last_q;

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CNT_ONE;
            2'b01:   fifo_count_d = fifo_count_q - CNT_ONE;
            default: fifo_count_d = fifo_count_q;
        endcase

        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        issued_d   = issued_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_odd_d   = rd_odd_q;
        rd_last_d  = rd_last_q;
        issue_even = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = S_READ;
                        busy_d     = 1'b1;
                        base_d     = start_base;
                        count_d    = start_count;
                        rd_en_d    = 1'b1;
                        rd_addr_d  = start_base;
                        rd_odd_d   = 1'b0;
                        rd_last_d  = (start_count == RUN_ONE);
                        issued_d   = RUN_ONE;
                        issue_even = 1'b1;
                    end
                end
            end
            S_READ: begin
                // reserved_q = pairs queued in the FIFO plus pairs still in flight
                if (issued_q == count_q) begin
                    state_d = S_DRAIN;
                end else if (issued_q[0] || (reserved_q < DEPTH_C)) begin
                    rd_en_d    = 1'b1;
                    rd_addr_d  = base_q + issued_q[ADDR_W-1:0];
                    rd_odd_d   = issued_q[0];
                    rd_last_d  = ((issued_q + RUN_ONE) == count_q);
                    issued_d   = issued_q + RUN_ONE;
                    issue_even = !issued_q[0];
                end
            end
            S_DRAIN: begin
                if (pop && head_entry[OUT_W]) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case ({issue_even, pop})
            2'b10:   reserved_d = reserved_q + CNT_ONE;
            2'b01:   reserved_d = reserved_q - CNT_ONE;
            default: reserved_d = reserved_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            count_q      <= '0;
            issued_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            rd_odd_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_odd_q    <= 1'b0;
            rsp_last_q   <= 1'b0;
            pack_q       <= '0;
            reserved_q   <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            count_q      <= count_d;
            issued_q     <= issued_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            rd_odd_q     <= rd_odd_d;
            rd_last_q    <= rd_last_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_odd_q    <= rsp_odd_d;
            rsp_last_q   <= rsp_last_d;
            pack_q       <= pack_d;
            reserved_q   <= reserved_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_q       <= fifo_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = fifo_nonempty;
    assign out_data  = fifo_nonempty ? head_entry[OUT_W-1:0] : '0;
    assign out_last  = fifo_nonempty && head_entry[OUT_W];

endmodule
